serializer_arbiter: RTL

Shares one serializer among NUM_REQ requesters using round-robin arbitration. It latches the granted requester's word and drives the serializer's data_in/start handshake, then watches busy for completion. Per-requester ack and done pulses report progress, and a timeout error is raised if the serializer never goes busy. It sits between the requesting blocks and a single serializer instance.

---
 rtl/serializer_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serializer_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of a single serializer: grants one requester at a time,
// hands its word to the serializer and reports ack/done/timeout per requester.
//
// state   | meaning
// IDLE    | no owner; arbitrate among req each cycle
// START   | word presented, ser_start held until ser_busy or timeout
// RUN     | serializer busy with the owner's word; wait for busy to fall
module serializer_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          timeout_err,
    output logic [ID_WIDTH-1:0]           active_id,
    output logic                          idle,
    output logic [DATA_WIDTH-1:0]         ser_data_in,
    output logic                          ser_start,
    input  logic                          ser_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [7:0]            tmo_cnt;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [DATA_WIDTH-1:0] grant_word;
    logic [ID_WIDTH-1:0]   next_ptr;

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first set request wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_word  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    grant_found = 1'b1;
                    grant_id    = ID_WIDTH'(i);
                    grant_word  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        if (int'(active_id) == NUM_REQ - 1) next_ptr = '0;
        else                                next_ptr = active_id + ID_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            ack         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            active_id   <= '0;
            idle        <= 1'b1;
            ser_data_in <= '0;
            ser_start   <= 1'b0;
        end else begin
            ack         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        ser_data_in <= grant_word;
                        active_id   <= grant_id;
                        ack         <= NUM_REQ'(1) << grant_id;
                        ser_start   <= 1'b1;
                        tmo_cnt     <= '0;
                        idle        <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (ser_busy) begin
                        ser_start <= 1'b0;
                        state     <= ST_RUN;
                    end else if (tmo_cnt == 8'(START_TIMEOUT - 1)) begin
                        // Serializer never responded: drop the word, no done pulse.
                        ser_start   <= 1'b0;
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        idle        <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (!ser_busy) begin
                        done   <= NUM_REQ'(1) << active_id;
                        rr_ptr <= next_ptr;
                        idle   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    ser_start <= 1'b0;
                    idle      <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
